stagepipe_fwd: RTL and testbench

Parametrised 5-stage in-order ALU pipeline with the stages IF, ID, EX, MEM and WB. It extends the basic stage pipe in four ways:
- configurable datapath and instruction-memory size
- internal register file with EX-stage operand forwarding from MEM and WB, so dependent back-to-back instructions compute correctly
- AND op and a HALT op with pipeline drain
- start/halted control, host register-file load port, debug read port and retire counter

It is used as the accelerator's compute core; a host loads operands, starts it, waits for halted and reads results.

---
 rtl/stagepipe_fwd.sv | 169 ++++++++++++++++
 tb/tb_stagepipe_fwd.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stagepipe_fwd.sv
// Five-stage in-order ALU pipeline (IF/ID/EX/MEM/WB) with EX-stage forwarding,
// HALT drain, host register load/debug ports and a retire counter.
module stagepipe_fwd #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [DATA_W-1:0]  cfg_wdata,
    input  logic [4:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               busy,
    output logic               halted,
    output logic [31:0]        retired_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_HALT = 2'b11} op_t;

    state_t              state;
    logic [IMEM_AW+1:0]  pc;
    logic [DATA_W-1:0]   regs [32];

    logic                if_valid;
    logic [31:0]         if_instr;
    logic                id_valid;
    op_t                 id_op;
    logic [4:0]          id_rs1, id_rs2, id_rd;
    logic                ex_valid;
    op_t                 ex_op;
    logic [4:0]          ex_rs1, ex_rs2, ex_rd;
    logic                mem_valid;
    op_t                 mem_op;
    logic [4:0]          mem_rd;
    logic [DATA_W-1:0]   mem_res;
    logic                wb_valid;
    op_t                 wb_op;
    logic [4:0]          wb_rd;
    logic [DATA_W-1:0]   wb_res;

    logic                running, host_ok, halt_in_id, mem_alu, wb_alu;
    logic [DATA_W-1:0]   opa, opb, alu_res;
    logic                unused_bits;

    assign running    = (state == S_RUN) || (state == S_DRAIN);
    assign host_ok    = !running;
    assign halt_in_id = (state == S_RUN) && id_valid && (id_op == OP_HALT);
    assign mem_alu    = mem_valid && (mem_op != OP_HALT);
    assign wb_alu     = wb_valid && (wb_op != OP_HALT);

    assign imem_addr   = pc[IMEM_AW+1:2];
    assign dbg_rdata   = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
    assign unused_bits = ^{if_instr[19:5], pc[1:0]};

    // MEM result has priority over WB; rs=0 never forwards.
    always_comb begin
        opa = regs[ex_rs1];
        if (ex_rs1 != 5'd0 && mem_alu && mem_rd == ex_rs1)
            opa = mem_res;
        else if (ex_rs1 != 5'd0 && wb_alu && wb_rd == ex_rs1)
            opa = wb_res;

        opb = regs[ex_rs2];
        if (ex_rs2 != 5'd0 && mem_alu && mem_rd == ex_rs2)
            opb = mem_res;
        else if (ex_rs2 != 5'd0 && wb_alu && wb_rd == ex_rs2)
            opb = wb_res;

        case (ex_op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state  <= S_RUN;
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (halt_in_id)
                        state <= S_DRAIN;
                    else
                        pc <= pc + (IMEM_AW+2)'(4);
                end
                S_DRAIN: begin
                    if (wb_valid && wb_op == OP_HALT) begin
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (host_ok && start)
                retired_cnt <= '0;
            else if (mem_alu)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end

    // On the HALT-in-ID edge the younger instruction in IF is squashed rather than advanced.
    always_ff @(posedge clk) begin
        if (rst || !running) begin
            if_valid  <= 1'b0;
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if_valid  <= (state == S_RUN) && !halt_in_id;
            if_instr  <= imem_rdata;

            id_valid  <= if_valid && !halt_in_id;
            id_op     <= op_t'(if_instr[31:30]);
            id_rs1    <= if_instr[29:25];
            id_rs2    <= if_instr[24:20];
            id_rd     <= if_instr[4:0];

            ex_valid  <= id_valid;
            ex_op     <= id_op;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;

            mem_valid <= ex_valid;
            mem_op    <= ex_op;
            mem_rd    <= ex_rd;
            mem_res   <= alu_res;

            wb_valid  <= mem_valid;
            wb_op     <= mem_op;
            wb_rd     <= mem_rd;
            wb_res    <= mem_res;
        end
    end

    // Register file is written on the MEM->WB edge so the result is visible one edge after MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (host_ok && cfg_we) begin
            if (cfg_addr != 5'd0)
                regs[cfg_addr] <= cfg_wdata;
        end else if (mem_alu && mem_rd != 5'd0) begin
            regs[mem_rd] <= mem_res;
        end
    end
endmodule

// File: tb/tb_stagepipe_fwd.sv
// Bench for stagepipe_fwd: an 8-bit core for programs/vectors and a 4-word
// instruction-memory core for PC wrap.
module tb_stagepipe_fwd;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, cfg_we, busy, halted;
    logic [4:0]    imem_addr, cfg_addr, dbg_addr;
    logic [31:0]   imem_rdata, retired_cnt;
    logic [DW-1:0] cfg_wdata, dbg_rdata;
    logic [31:0]   imem [32];
    assign imem_rdata = imem[imem_addr];

    stagepipe_fwd #(.DATA_W(DW), .IMEM_AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata), .busy(busy), .halted(halted), .retired_cnt(retired_cnt)
    );

    logic          w_rst, w_start, w_cfg_we, w_busy, w_halted;
    logic [1:0]    w_imem_addr;
    logic [4:0]    w_cfg_addr, w_dbg_addr;
    logic [31:0]   w_imem_rdata, w_cfg_wdata, w_dbg_rdata, w_retired;
    logic [31:0]   wmem [4];
    assign w_imem_rdata = wmem[w_imem_addr];

    stagepipe_fwd #(.DATA_W(32), .IMEM_AW(2)) dut_wrap (
        .clk(clk), .rst(w_rst), .start(w_start), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .cfg_we(w_cfg_we), .cfg_addr(w_cfg_addr), .cfg_wdata(w_cfg_wdata), .dbg_addr(w_dbg_addr),
        .dbg_rdata(w_dbg_rdata), .busy(w_busy), .halted(w_halted), .retired_cnt(w_retired)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {string name; logic [4:0] r; logic [31:0] v;} exp_t;
    exp_t sb[$];

    typedef struct {string name; logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] y;} vec_t;
    vec_t vt[6];

    localparam logic [31:0] HALT = 32'hC000_0000;

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd);
        return {op, rs1, rs2, 15'd0, rd};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = 32'(dbg_rdata);
    endtask

    task automatic cfg(input logic [4:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic fill_imem(input logic [31:0] w);
        for (int i = 0; i < 32; i++) imem[i] = w;
    endtask

    task automatic wait_halted(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick;
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic expect_reg(input string name, input logic [4:0] r, input logic [31:0] v);
        exp_t e;
        e.name = name; e.r = r; e.v = v;
        sb.push_back(e);
    endtask

    task automatic drain_sb;
        exp_t e;
        logic [31:0] g;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.r, g);
            check(e.name, g, e.v);
        end
    endtask

    initial begin
        logic [31:0] g;
        int ea, er;

        vt[0] = '{"sub_wrap", 2'b01, 8'h00, 8'h01, 8'hFF};
        vt[1] = '{"add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00};
        vt[2] = '{"and_mix",  2'b10, 8'hF0, 8'h3C, 8'h30};
        vt[3] = '{"sub_pos",  2'b01, 8'h10, 8'h03, 8'h0D};
        vt[4] = '{"add_pos",  2'b00, 8'h07, 8'h09, 8'h10};
        vt[5] = '{"and_one",  2'b10, 8'hFF, 8'h01, 8'h01};

        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; dbg_addr = '0;
        w_rst = 1'b1; w_start = 1'b0; w_cfg_we = 1'b0; w_cfg_addr = '0; w_cfg_wdata = '0; w_dbg_addr = '0;
        fill_imem(enc(2'b00, 5'd0, 5'd0, 5'd3));
        for (int i = 0; i < 4; i++) wmem[i] = enc(2'b00, 5'd1, 5'd2, 5'd1);
        tick; tick;
        rst = 1'b0; w_rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", retired_cnt, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Dependent program with a cycle-accurate walk through the HALT drain.
        cfg(5'd1, 8'd5);
        cfg(5'd2, 8'd3);
        fill_imem(enc(2'b00, 5'd1, 5'd1, 5'd6));
        imem[0] = enc(2'b00, 5'd1, 5'd2, 5'd3);
        imem[1] = enc(2'b01, 5'd3, 5'd1, 5'd4);
        imem[2] = enc(2'b00, 5'd3, 5'd4, 5'd5);
        imem[3] = HALT;
        expect_reg("p1_r3", 5'd3, 32'd8);
        expect_reg("p1_r4", 5'd4, 32'd3);
        expect_reg("p1_r5", 5'd5, 32'd11);
        expect_reg("p1_r6_squashed", 5'd6, 32'd0);
        expect_reg("p1_r1_cfg_ignored", 5'd1, 32'd5);
        go;
        check("p1_addr0", 32'(imem_addr), 32'd0);
        check("p1_busy0", 32'(busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) begin cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = 8'h55; end
            if (k == 7) start = 1'b1;
            tick;
            cfg_we = 1'b0; start = 1'b0;
            ea = (k <= 5) ? k : 5;
            er = (k <= 4) ? 0 : ((k >= 7) ? 3 : k - 4);
            check("p1_addr", 32'(imem_addr), 32'(ea));
            check("p1_retired", retired_cnt, 32'(er));
            check("p1_busy", 32'(busy), (k <= 8) ? 32'd1 : 32'd0);
            check("p1_halted", 32'(halted), (k == 9) ? 32'd1 : 32'd0);
            if (k == 4) begin rd(5'd3, g); check("p1_r3_before_wb", g, 32'd0); end
            if (k == 5) begin rd(5'd3, g); check("p1_r3_at_edge5", g, 32'd8); end
        end
        drain_sb;

        // Restart from HALTED.
        go;
        check("rs_addr", 32'(imem_addr), 32'd0);
        check("rs_retired", retired_cnt, 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_halted", 32'(halted), 32'd0);
        wait_halted(40);
        check("rs_retired_end", retired_cnt, 32'd3);

        // Wrap and dependent AND.
        cfg(5'd1, 8'h00);
        cfg(5'd2, 8'h01);
        fill_imem(enc(2'b00, 5'd0, 5'd0, 5'd8));
        imem[0] = enc(2'b01, 5'd1, 5'd2, 5'd7);
        imem[1] = enc(2'b10, 5'd7, 5'd2, 5'd8);
        imem[2] = HALT;
        expect_reg("wrap_r7", 5'd7, 32'hFF);
        expect_reg("and_r8", 5'd8, 32'h01);
        go;
        wait_halted(40);
        drain_sb;

        // Single-op vectors.
        for (int i = 0; i < 6; i++) begin
            cfg(5'd1, vt[i].a);
            cfg(5'd2, vt[i].b);
            fill_imem(enc(2'b00, 5'd0, 5'd0, 5'd3));
            imem[0] = enc(vt[i].op, 5'd1, 5'd2, 5'd3);
            imem[1] = HALT;
            expect_reg(vt[i].name, 5'd3, 32'(vt[i].y));
            go;
            wait_halted(40);
            drain_sb;
            check("vec_retired", retired_cnt, 32'd1);
        end

        // Register 0 is never written nor forwarded.
        cfg(5'd1, 8'd7);
        cfg(5'd2, 8'd3);
        fill_imem(enc(2'b00, 5'd0, 5'd0, 5'd3));
        imem[0] = enc(2'b00, 5'd1, 5'd2, 5'd0);
        imem[1] = enc(2'b00, 5'd0, 5'd2, 5'd9);
        imem[2] = HALT;
        expect_reg("r0_zero", 5'd0, 32'd0);
        expect_reg("r9_no_fwd", 5'd9, 32'd3);
        go;
        wait_halted(40);
        drain_sb;
        check("r0_retired", retired_cnt, 32'd2);

        // Reset while the r3 writer is in EX.
        rst = 1'b1; tick; rst = 1'b0;
        cfg(5'd1, 8'd5);
        cfg(5'd2, 8'd3);
        fill_imem(HALT);
        imem[0] = enc(2'b00, 5'd1, 5'd2, 5'd3);
        go;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rd(5'd3, g);
        check("mr_r3", g, 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_halted", 32'(halted), 32'd0);
        check("mr_addr", 32'(imem_addr), 32'd0);
        check("mr_retired", retired_cnt, 32'd0);
        tick; tick; tick;
        rd(5'd3, g);
        check("mr_r3_later", g, 32'd0);
        rd(5'd1, g);
        check("mr_r1_cleared", g, 32'd0);

        // PC wrap on a 4-word instruction memory, no HALT.
        w_cfg_we = 1'b1; w_cfg_addr = 5'd2; w_cfg_wdata = 32'd1;
        tick;
        w_cfg_we = 1'b0;
        w_start = 1'b1;
        tick;
        w_start = 1'b0;
        check("pw_addr", 32'(w_imem_addr), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k <= 5) check("pw_addr", 32'(w_imem_addr), 32'(k % 4));
            check("pw_retired", w_retired, 32'((k > 4) ? k - 4 : 0));
        end
        w_dbg_addr = 5'd1;
        #1;
        check("pw_r1_chain", w_dbg_rdata, 32'd8);
        check("pw_busy", 32'(w_busy), 32'd1);
        w_rst = 1'b1;
        tick;
        w_rst = 1'b0;
        check("pw_rst_busy", 32'(w_busy), 32'd0);
        check("pw_rst_retired", w_retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
